// File: rtl/pll_reset_sequencer.sv
// PLL lock to synchronous core reset sequencer: lock stability window, hold, run, lock-loss counting.
// Optional lock-wait watchdog enabled by defining PLL_RESET_SEQ_TIMEOUT_EN.
module pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int SYNC_STAGES        = 2,
    parameter int LOSS_CNT_W         = 8,
    parameter int TIMEOUT_CYCLES     = 65536
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  lock,
    input  logic                  ext_rst_req,
    output logic                  core_rst,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic                  lock_timeout
);

    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                      : RESET_HOLD_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
    logic                    core_rst_q, ready_q;
    logic [SYNC_STAGES-1:0]  lock_sync_q, req_sync_q;
    logic                    lock_s, req_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_sync_q <= '0;
            req_sync_q  <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], lock};
            req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], ext_rst_req};
        end
    end

    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    assign req_s  = req_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            loss_q     <= '0;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            loss_q     <= loss_d;
            core_rst_q <= (state_d != RUN);
            ready_q    <= (state_d == RUN);
        end
    end

    // Loss of lock is checked first in every state so it always beats a reset request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) state_d = STABLE;
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (req_s) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    if (loss_q != '1) loss_d = loss_q + 1'b1;
                end else if (req_s) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    assign core_rst      = core_rst_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_q;

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;
    logic            timeout_q;

    // Watchdog saturates at its limit; the flag stays set until reset_n.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_d == RUN)
                wd_q <= '0;
            else if ((state_q == WAIT_LOCK || state_q == STABLE) && wd_q != WD_LAST)
                wd_q <= wd_q + 1'b1;
            if (wd_q == WD_LAST) timeout_q <= 1'b1;
        end
    end

    assign lock_timeout = timeout_q;
`else
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer (L=8, H=4, SYNC=2, LOSS_CNT_W=2, TIMEOUT=32).
module tb_pll_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       lock = 1'b0;
    logic       ext_rst_req = 1'b0;
    logic       core_rst, ready, lock_timeout;
    logic [1:0] lock_loss_cnt;

    int checks = 0;
    int failures = 0;

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    localparam int EXP_TO = 1;
`else
    localparam int EXP_TO = 0;
`endif

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .RESET_HOLD_CYCLES (4),
        .SYNC_STAGES       (2),
        .LOSS_CNT_W        (2),
        .TIMEOUT_CYCLES    (32)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .lock         (lock),
        .ext_rst_req  (ext_rst_req),
        .core_rst     (core_rst),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt),
        .lock_timeout (lock_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        int drop_cycles;
        int exp_assert;
        int exp_loss;
    } drop_vec_t;

    typedef struct {
        string name;
        int    exp;
    } sb_t;

    drop_vec_t vecs[4];
    sb_t       sb_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input int exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input int act);
        sb_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk(e.name, act, e.exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Edges until the selected output reaches val; -1 if the budget runs out.
    task automatic wait_for(input bit sel_ready, input logic val, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clock);
            #1;
            if ((sel_ready ? ready : core_rst) === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic relock(input string name);
        int n;
        lock = 1'b1;
        wait_for(1'b0, 1'b0, 40, n);
        chk(name, n, 15);
        chk({name, "_ready"}, int'(ready), 1);
        tick(3);
        chk({name, "_no_glitch"}, int'(core_rst), 0);
    endtask

    initial begin
        int n;
        int bad;
        vecs = '{'{3, 3, 1}, '{3, 3, 2}, '{3, 3, 3}, '{4, 3, 3}};

        tick(3);
        chk("reset_core_rst", int'(core_rst), 1);
        chk("reset_ready", int'(ready), 0);
        chk("reset_loss_cnt", int'(lock_loss_cnt), 0);
        chk("reset_timeout", int'(lock_timeout), 0);

        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (core_rst !== 1'b1 || ready !== 1'b0 || lock_loss_cnt !== 2'd0) bad++;
        end
        chk("idle_no_lock_violations", bad, 0);
        chk("timeout_after_idle", int'(lock_timeout), EXP_TO);

        relock("first_release_edges");
        chk("first_release_loss_cnt", int'(lock_loss_cnt), 0);
        chk("timeout_sticky_in_run", int'(lock_timeout), EXP_TO);

        // Abort the stability window partway, then restore lock.
        reset_n = 1'b0;
        #1;
        chk("async_reset_mid_run", int'(core_rst), 1);
        lock = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        lock = 1'b1;
        tick(5);
        lock = 1'b0;
        tick(3);
        relock("release_after_glitch");
        chk("glitch_loss_cnt", int'(lock_loss_cnt), 0);

        foreach (vecs[i]) begin
            push_exp($sformatf("loss_cnt_drop%0d", i), vecs[i].exp_loss);
            lock = 1'b0;
            wait_for(1'b0, 1'b1, 10, n);
            chk($sformatf("drop%0d_assert_edges", i), n, vecs[i].exp_assert);
            tick(vecs[i].drop_cycles);
            pop_chk(int'(lock_loss_cnt));
            chk($sformatf("drop%0d_ready_low", i), int'(ready), 0);
            relock($sformatf("drop%0d_relock", i));
        end

        // Request pulse of 10 cycles in RUN.
        ext_rst_req = 1'b1;
        wait_for(1'b0, 1'b1, 10, n);
        chk("req_assert_edges", n, 3);
        if (n > 0 && n < 10) tick(10 - n);
        ext_rst_req = 1'b0;
        wait_for(1'b1, 1'b1, 20, n);
        chk("req_release_edges", n, 6);
        chk("req_loss_unchanged", int'(lock_loss_cnt), 3);

        reset_n = 1'b0;
        #1;
        chk("async_reset_clears_loss", int'(lock_loss_cnt), 0);
        chk("async_reset_ready_low", int'(ready), 0);
        tick(1);
        reset_n = 1'b1;
        wait_for(1'b0, 1'b0, 40, n);
        chk("release_after_reset", n, 15);

        // Request and lock loss together: loss wins and is counted.
        push_exp("simul_loss_cnt", 1);
        lock = 1'b0;
        ext_rst_req = 1'b1;
        wait_for(1'b0, 1'b1, 10, n);
        chk("simul_assert_edges", n, 3);
        tick(5);
        pop_chk(int'(lock_loss_cnt));
        ext_rst_req = 1'b0;
        tick(3);
        relock("simul_relock_edges");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
